// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths and requester ids for the two-port memory arbiter.
package mem_arb_pkg;
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;
    function automatic req_id_t other(input req_id_t id);
        return (id == REQ_A) ? REQ_B : REQ_A;
    endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-side signals of the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
);
    logic              req_a, we_a, gnt_a, rvalid_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a, rdata_a;
    logic              req_b, we_b, gnt_b, rvalid_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b, rdata_b;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr, mem_raddr1, mem_raddr2;
    logic [DATA_W-1:0] mem_wdata, mem_rdata1, mem_rdata2;
    modport slave (
        input  req_a, we_a, addr_a, wdata_a, req_b, we_b, addr_b, wdata_b,
        input  mem_rdata1, mem_rdata2,
        output gnt_a, rdata_a, rvalid_a, gnt_b, rdata_b, rvalid_b,
        output mem_we, mem_waddr, mem_wdata, mem_raddr1, mem_raddr2
    );
    modport master (
        output req_a, we_a, addr_a, wdata_a, req_b, we_b, addr_b, wdata_b,
        output mem_rdata1, mem_rdata2,
        input  gnt_a, rdata_a, rvalid_a, gnt_b, rdata_b, rvalid_b,
        input  mem_we, mem_waddr, mem_wdata, mem_raddr1, mem_raddr2
    );
endinterface

// File: rtl/arb_rr2.sv
// arb_rr2: two-way round-robin arbiter; one-hot grant, pointer moves to the loser.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    req_id_t rr_ptr;
    always_comb gnt = !reset_n ? 2'b00 : (&req) ? ((rr_ptr == REQ_A) ? 2'b01 : 2'b10) : req;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rr_ptr <= REQ_A;
        else if (|gnt)
            rr_ptr <= other(gnt[0] ? REQ_A : REQ_B);
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: dedicated read ports per requester with one-cycle registered
// read data, and a shared write port arbitrated round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input logic          clk,
    input logic          reset_n,
    mem_arbiter_if.slave bus
);
    logic              rd_a, rd_b;
    logic [1:0]        wgnt;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata, rdata_a, rdata_b;
    logic              rvalid_a, rvalid_b;
    assign rd_a = reset_n & bus.req_a & ~bus.we_a;
    assign rd_b = reset_n & bus.req_b & ~bus.we_b;
    arb_rr2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({bus.req_b & bus.we_b, bus.req_a & bus.we_a}),
        .gnt     (wgnt)
    );
    always_comb begin
        waddr          = wgnt[0] ? bus.addr_a : wgnt[1] ? bus.addr_b : '0;
        wdata          = wgnt[0] ? bus.wdata_a : wgnt[1] ? bus.wdata_b : '0;
        bus.gnt_a      = rd_a | wgnt[0];
        bus.gnt_b      = rd_b | wgnt[1];
        bus.mem_we     = |wgnt;
        bus.mem_waddr  = waddr;
        bus.mem_wdata  = wdata;
        bus.mem_raddr1 = bus.addr_a;
        bus.mem_raddr2 = bus.addr_b;
        bus.rdata_a    = rdata_a;
        bus.rdata_b    = rdata_b;
        bus.rvalid_a   = rvalid_a;
        bus.rvalid_b   = rvalid_b;
    end
    // Read data is captured pre-write, so a same-address write is not forwarded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            rdata_a  <= '0;
            rdata_b  <= '0;
        end else begin
            rvalid_a <= rd_a;
            rvalid_b <= rd_b;
            rdata_a  <= rd_a ? bus.mem_rdata1 : rdata_a;
            rdata_b  <= rd_b ? bus.mem_rdata2 : rdata_b;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with a read-data scoreboard and an external memory.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus();
    mem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

    logic [7:0] mem [16] = '{1: 8'hA1, default: 8'h00};
    assign bus.mem_rdata1 = mem[bus.mem_raddr1];
    assign bus.mem_rdata2 = mem[bus.mem_raddr2];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;

    int checks = 0;
    int errors = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid pops the oldest expected read for that requester.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.rvalid_a) begin
                if (qa.size() == 0) chk("rvalid_a unexpected", 32'(bus.rvalid_a), 0);
                else chk("rdata_a", 32'(bus.rdata_a), 32'(qa.pop_front()));
            end
            if (bus.rvalid_b) begin
                if (qb.size() == 0) chk("rvalid_b unexpected", 32'(bus.rvalid_b), 0);
                else chk("rdata_b", 32'(bus.rdata_b), 32'(qb.pop_front()));
            end
        end
    end

    task automatic drive(input logic ra, input logic wa, input logic [3:0] aa, input logic [7:0] da,
                         input logic rb, input logic wb, input logic [3:0] ab, input logic [7:0] db);
        bus.req_a = ra; bus.we_a = wa; bus.addr_a = aa; bus.wdata_a = da;
        bus.req_b = rb; bus.we_b = wb; bus.addr_b = ab; bus.wdata_b = db;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with random traffic on the inputs
        drive(1'b1, 1'($urandom), 4'($urandom), 8'($urandom), 1'b1, 1'($urandom), 4'($urandom), 8'($urandom));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst gnt_a", 32'(bus.gnt_a), 0);
        chk("rst gnt_b", 32'(bus.gnt_b), 0);
        chk("rst rvalid_a", 32'(bus.rvalid_a), 0);
        chk("rst rvalid_b", 32'(bus.rvalid_b), 0);
        chk("rst mem_we", 32'(bus.mem_we), 0);
        chk("rst rdata_a", 32'(bus.rdata_a), 0);
        chk("rst rdata_b", 32'(bus.rdata_b), 0);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;

        // Lone write from b after release
        next_cycle();
        drive(0, 0, 0, 0, 1, 1, 4'd9, 8'h55);
        @(negedge clk);
        chk("b write gnt_b", 32'(bus.gnt_b), 1);
        chk("b write gnt_a", 32'(bus.gnt_a), 0);
        chk("b write mem_we", 32'(bus.mem_we), 1);
        chk("b write waddr", 32'(bus.mem_waddr), 9);
        chk("b write wdata", 32'(bus.mem_wdata), 32'h55);

        // Write contention, pointer at a
        next_cycle();
        drive(1, 1, 4'd2, 8'h11, 1, 1, 4'd2, 8'h22);
        @(negedge clk);
        chk("cont1 gnt_a", 32'(bus.gnt_a), 1);
        chk("cont1 gnt_b", 32'(bus.gnt_b), 0);
        chk("cont1 wdata", 32'(bus.mem_wdata), 32'h11);
        next_cycle();
        @(negedge clk);
        chk("cont2 gnt_a", 32'(bus.gnt_a), 0);
        chk("cont2 gnt_b", 32'(bus.gnt_b), 1);
        chk("cont2 wdata", 32'(bus.mem_wdata), 32'h22);
        next_cycle();
        drive(1, 0, 4'd2, 0, 0, 0, 0, 0);
        qa.push_back(8'h22);
        @(negedge clk);
        chk("mem[2]", 32'(mem[2]), 32'h22);
        chk("read2 gnt_a", 32'(bus.gnt_a), 1);
        chk("read2 mem_we", 32'(bus.mem_we), 0);
        chk("read2 waddr", 32'(bus.mem_waddr), 0);

        // Single write then read
        next_cycle();
        drive(1, 1, 4'd5, 8'h3C, 0, 0, 0, 0);
        @(negedge clk);
        chk("wr5 gnt_a", 32'(bus.gnt_a), 1);
        chk("wr5 waddr", 32'(bus.mem_waddr), 5);
        next_cycle();
        drive(1, 0, 4'd5, 0, 0, 0, 0, 0);
        qa.push_back(8'h3C);
        @(negedge clk);
        chk("rd5 gnt_a", 32'(bus.gnt_a), 1);

        // Concurrent reads of one address
        next_cycle();
        drive(1, 0, 4'd1, 0, 1, 0, 4'd1, 0);
        qa.push_back(8'hA1);
        qb.push_back(8'hA1);
        @(negedge clk);
        chk("crd gnt_a", 32'(bus.gnt_a), 1);
        chk("crd gnt_b", 32'(bus.gnt_b), 1);
        chk("crd raddr2", 32'(bus.mem_raddr2), 1);

        // Read/write collision on address 7
        next_cycle();
        drive(1, 1, 4'd7, 8'hFF, 1, 0, 4'd7, 0);
        qb.push_back(8'h00);
        @(negedge clk);
        chk("coll gnt_a", 32'(bus.gnt_a), 1);
        chk("coll gnt_b", 32'(bus.gnt_b), 1);
        chk("coll mem_we", 32'(bus.mem_we), 1);
        next_cycle();
        drive(1, 0, 4'd7, 0, 0, 0, 0, 0);
        qa.push_back(8'hFF);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("idle gnt_a", 32'(bus.gnt_a), 0);
        chk("idle gnt_b", 32'(bus.gnt_b), 0);
        next_cycle();
        @(negedge clk);
        chk("hold rvalid_a", 32'(bus.rvalid_a), 0);
        chk("hold rdata_a", 32'(bus.rdata_a), 32'hFF);

        // Mid-op reset with contention pending; pointer was left at b
        next_cycle();
        drive(1, 1, 4'd3, 8'hAA, 1, 1, 4'd3, 8'hBB);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst mem_we", 32'(bus.mem_we), 0);
        chk("midrst gnt_a", 32'(bus.gnt_a), 0);
        chk("midrst gnt_b", 32'(bus.gnt_b), 0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("post rst gnt_a", 32'(bus.gnt_a), 1);
        chk("post rst gnt_b", 32'(bus.gnt_b), 0);
        next_cycle();
        @(negedge clk);
        chk("post rst2 gnt_b", 32'(bus.gnt_b), 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mem[3]", 32'(mem[3]), 32'hBB);
        chk("mem[9]", 32'(mem[9]), 32'h55);

        repeat (2) next_cycle();
        chk("qa drained", 32'(qa.size()), 0);
        chk("qb drained", 32'(qb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
